fpu_stim_gen: RTL and testbench
===============================

# fpu_stim_gen

Hardware stimulus generator that sits directly upstream of `fpu_top`. It produces pseudo-random IEEE-754 single-precision operand pairs and op codes, and presents them over a valid/ready handshake. It sweeps ADD, SUB, MUL and DIV in order, issuing `NUM_TESTS_PER_OP` vectors each. A programmable fraction of operands is replaced by special values: ±Inf, qNaN, and the minimum denormal.

## Interface
- `NUM_TESTS_PER_OP`, default 100: vectors issued per op code, legal range 1..65535.
- `SEED`, default 32'h0000002A: LFSR reset value; 0 is replaced by 32'h00000001.
- `SPECIAL_THRESH`, default 6: operand is special when `word[6:0] < SPECIAL_THRESH` (out of 128); 0 disables, 128 forces all.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: begins a sweep; sampled only in IDLE or DONE.
- `out_valid  out  1`: op/a/b hold a valid vector.
- `out_ready  in  1`: consumer accepts the vector on an edge where `out_valid && out_ready`.
- `op  out  2`: 00 add, 01 sub, 10 mul, 11 div.
- `a  out  32`, `b  out  32`: operands.
- `test_idx  out  16`: index of the presented vector within the current op.
- `busy  out  1`: high in all GEN and PRESENT states.
- `done  out  1`: high in DONE.

## Operation
- LFSR: 32-bit Galois, `next = {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 0)`. It advances only on edges leaving a GEN state. The "word" consumed in a GEN state is the current LFSR value.
- States:
  - IDLE: `start` → GEN_A0.
  - GEN_A0: latch `word` as selector for a → GEN_A1.
  - GEN_A1: compute a → GEN_B0.
  - GEN_B0: latch selector for b → GEN_B1.
  - GEN_B1: compute b → PRESENT.
  - PRESENT: waits for handshake.
  - DONE: `start` → GEN_A0 with op=0, idx=0.
- Operand rule, selector s, value word v:
  - If `s[6:0] < SPECIAL_THRESH`, the operand is chosen by `s[8:7]`: 0 → 7F800000, 1 → FF800000, 2 → 7FC00000, 3 → 00000001. The GEN_x1 word is still consumed.
  - Otherwise the operand is v, with exponent `v[30:23]==8'hFF` rewritten to 8'hFE. Sign and mantissa are unchanged.
- Handshake in PRESENT advances the counters:
  - If `test_idx == NUM_TESTS_PER_OP-1`: idx ← 0 and op ← op+1. If op was 11, go to DONE; otherwise go to GEN_A0.
  - Else idx ← idx+1 → GEN_A0.
- `start` is ignored in GEN/PRESENT states. LFSR is not reseeded on restart from DONE; it is reseeded only by reset.
- In DONE, op and idx read 0 and `out_valid` = 0.

## Timing
- Reset values (async, immediate):
  - `out_valid`=0, `op`=0, `a`=0, `b`=0, `test_idx`=0, `busy`=0, `done`=0.
  - state=IDLE, LFSR=SEED, or 1 if SEED==0.
- Latency: if `start` is sampled at edge E0, `out_valid` rises after edge E4. GEN states run at E0..E4.
- Throughput: a handshake at edge H gives the next `out_valid` after H+4, i.e. 5 cycles per vector with `out_ready` tied high.
- `out_valid` is registered and drops after the handshake edge. It never depends combinationally on `out_ready`.
- op/a/b/test_idx are stable while `out_valid && !out_ready`. They may change only after a handshake or a reset.
- Full sweep: 4×`NUM_TESTS_PER_OP` handshakes. `done` rises after the edge of the final handshake.
- Reset asserted mid-sweep clears everything at once. After release, the vector sequence repeats bit-exactly from the first vector.

## Test plan
- Reset: drive `rst_n`=0 with toggling inputs → all outputs 0, IDLE. After release with no `start`, `out_valid` stays 0 for 20 cycles.
- SEED=1, SPECIAL_THRESH=6, pulse `start`:
  - first vector after 4 edges: op=00, a=7F800000, b=7F800000, test_idx=0;
  - LFSR words consumed are 00000001, 80200003, C0300002, 60180001.
- Defaults with `out_ready`=1:
  - exactly 400 handshakes; op sequence 00×100, 01×100, 10×100, 11×100; test_idx wraps 99 → 0;
  - then `done`=1 and `busy`=0;
  - a second `start` yields 400 more vectors that differ from the first run.
- Backpressure: `out_ready` random at 30% high → op/a/b never change while `out_valid && !out_ready`. The vector stream matches the `out_ready`=1 run.
- SPECIAL_THRESH=0 → no operand with exponent FF over a full sweep. SPECIAL_THRESH=128 → every operand is in {7F800000, FF800000, 7FC00000, 00000001}.
- `rst_n` pulsed low at vector 150 → first post-reset vector equals the first vector of a fresh run. `start` held high throughout a sweep causes no restart before DONE.

Source files
------------

// File: rtl/fpu_stim_gen_if.sv
// Vector handshake bundle between the stimulus generator and the FPU under test.
interface fpu_stim_gen_if;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [15:0] test_idx;

  modport master (
    output out_valid, op, a, b, test_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, op, a, b, test_idx,
    output out_ready
  );
endinterface

// File: rtl/fpu_stim_gen.sv
// Pseudo-random single-precision operand generator sweeping ADD/SUB/MUL/DIV,
// with a programmable share of special operands (+/-Inf, qNaN, min denormal).
module fpu_stim_gen #(
  parameter int unsigned NUM_TESTS_PER_OP = 100,
  parameter logic [31:0] SEED             = 32'h0000002A,
  parameter int unsigned SPECIAL_THRESH   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  fpu_stim_gen_if.master vec,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GEN_A0  = 3'd1;
  localparam logic [2:0] S_GEN_A1  = 3'd2;
  localparam logic [2:0] S_GEN_B0  = 3'd3;
  localparam logic [2:0] S_GEN_B1  = 3'd4;
  localparam logic [2:0] S_PRESENT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]  THRESH    = 8'(SPECIAL_THRESH);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_TESTS_PER_OP - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] lfsr_q,  lfsr_d;
  logic [8:0]  sel_q,   sel_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [1:0]  op_q,    op_d;
  logic [15:0] idx_q,   idx_d;
  logic        valid_q, valid_d;
  logic [31:0] lfsr_next;

  function automatic logic [31:0] make_operand(input logic [8:0] sel, input logic [31:0] val);
    logic [31:0] res;
    if ({1'b0, sel[6:0]} < THRESH) begin
      case (sel[8:7])
        2'd0:    res = 32'h7F80_0000;
        2'd1:    res = 32'hFF80_0000;
        2'd2:    res = 32'h7FC0_0000;
        default: res = 32'h0000_0001;
      endcase
    end else begin
      // Clamp the exponent so random words never produce Inf/NaN by accident.
      res = {val[31], (val[30:23] == 8'hFF) ? 8'hFE : val[30:23], val[22:0]};
    end
    return res;
  endfunction

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_GEN_A0;
          op_d    = '0;
          idx_d   = '0;
        end
      end
      S_GEN_A0: begin
        sel_d   = lfsr_q[8:0];
        lfsr_d  = lfsr_next;
        state_d = S_GEN_A1;
      end
      S_GEN_A1: begin
        a_d     = make_operand(sel_q, lfsr_q);
        lfsr_d  = lfsr_next;
        state_d = S_GEN_B0;
      end
      S_GEN_B0: begin
        sel_d   = lfsr_q[8:0];
        lfsr_d  = lfsr_next;
        state_d = S_GEN_B1;
      end
      S_GEN_B1: begin
        b_d     = make_operand(sel_q, lfsr_q);
        lfsr_d  = lfsr_next;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_q && vec.out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            op_d    = op_q + 2'd1;
            state_d = (op_q == 2'b11) ? S_DONE : S_GEN_A0;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_GEN_A0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_INIT;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign vec.out_valid = valid_q;
  assign vec.op        = op_q;
  assign vec.a         = a_q;
  assign vec.b         = b_q;
  assign vec.test_idx  = idx_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_fpu_stim_gen.sv
// Scoreboard bench for fpu_stim_gen: expected vectors are queued per sweep, a monitor checks them.
module tb_fpu_stim_gen;
  localparam int unsigned N = 100;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] idx;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_all = 1'b0, start_none = 1'b0;
  logic busy, done, busy_all, done_all, busy_none, done_none;

  fpu_stim_gen_if vif();
  fpu_stim_gen_if if_all();
  fpu_stim_gen_if if_none();

  fpu_stim_gen #(.NUM_TESTS_PER_OP(N), .SEED(32'h1), .SPECIAL_THRESH(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vif), .busy(busy), .done(done));
  fpu_stim_gen #(.NUM_TESTS_PER_OP(4), .SEED(32'h0), .SPECIAL_THRESH(128)) u_all (
    .clk(clk), .rst_n(rst_n), .start(start_all), .vec(if_all), .busy(busy_all), .done(done_all));
  fpu_stim_gen #(.NUM_TESTS_PER_OP(25), .SEED(32'hDEADBEEF), .SPECIAL_THRESH(0)) u_none (
    .clk(clk), .rst_n(rst_n), .start(start_none), .vec(if_none), .busy(busy_none), .done(done_none));

  always #5 clk = ~clk;

  vec_t        exp_q[$];
  logic [31:0] m_lfsr;
  int          compared = 0, mismatched = 0;
  int          hs = 0, hs_all = 0, hs_none = 0;
  bit          ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nx(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] oper(input logic [31:0] s, input logic [31:0] v);
    logic [1:0] k;
    k = s[8:7];
    if (s[6:0] < 7'd6) begin
      case (k)
        2'd0:    return 32'h7F800000;
        2'd1:    return 32'hFF800000;
        2'd2:    return 32'h7FC00000;
        default: return 32'h00000001;
      endcase
    end
    return {v[31], (v[30:23] == 8'hFF) ? 8'hFE : v[30:23], v[22:0]};
  endfunction

  function automatic logic is_special(input logic [31:0] x);
    return (x == 32'h7F800000) || (x == 32'hFF800000) || (x == 32'h7FC00000) || (x == 32'h00000001);
  endfunction

  task automatic push_run();
    vec_t v;
    logic [31:0] s;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < int'(N); i++) begin
        v.op  = 2'(o);
        v.idx = 16'(i);
        s = m_lfsr; m_lfsr = nx(m_lfsr);
        v.a = oper(s, m_lfsr); m_lfsr = nx(m_lfsr);
        s = m_lfsr; m_lfsr = nx(m_lfsr);
        v.b = oper(s, m_lfsr); m_lfsr = nx(m_lfsr);
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit fin);
    fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_first_vector(input string tag);
    check({tag, "_valid"}, 32'(vif.out_valid), 32'h1);
    check({tag, "_op"},    32'(vif.op),        32'h0);
    check({tag, "_idx"},   32'(vif.test_idx),  32'h0);
    check({tag, "_a"},     vif.a,              32'h7F800000);
    check({tag, "_b"},     vif.b,              32'h7F800000);
  endtask

  // Presented vector must match the queue head on every cycle it is valid,
  // which also catches any change while stalled.
  always @(negedge clk) begin
    if (rst_n && vif.out_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_without_expected", 32'(vif.out_valid), 32'h0);
      end else begin
        check("op",  32'(vif.op),       32'(exp_q[0].op));
        check("idx", 32'(vif.test_idx), 32'(exp_q[0].idx));
        check("a",   vif.a,             exp_q[0].a);
        check("b",   vif.b,             exp_q[0].b);
        if (vif.out_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_all.out_valid && if_all.out_ready) begin
      hs_all++;
      check("all_special_a", 32'(is_special(if_all.a)), 32'h1);
      check("all_special_b", 32'(is_special(if_all.b)), 32'h1);
    end
    if (rst_n && if_none.out_valid && if_none.out_ready) begin
      hs_none++;
      check("none_exp_a", 32'(if_none.a[30:23] == 8'hFF), 32'h0);
      check("none_exp_b", 32'(if_none.b[30:23] == 8'hFF), 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.out_ready = 1'b0;
    if_all.out_ready = 1'b1;
    if_none.out_ready = 1'b1;

    // Reset with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = (i % 2 == 0);
      vif.out_ready = (i % 2 != 0);
      check("rst_valid", 32'(vif.out_valid), 32'h0);
      check("rst_op",    32'(vif.op),        32'h0);
      check("rst_a",     vif.a,              32'h0);
      check("rst_b",     vif.b,              32'h0);
      check("rst_idx",   32'(vif.test_idx),  32'h0);
      check("rst_busy",  32'(busy),          32'h0);
      check("rst_done",  32'(done),          32'h0);
    end
    start = 1'b0;
    vif.out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_valid", 32'(vif.out_valid), 32'h0);
      check("idle_busy",  32'(busy),          32'h0);
    end

    start_all = 1'b1; start_none = 1'b1;
    @(posedge clk); #1 start_all = 1'b0; start_none = 1'b0;

    // Sweep 1: latency, hand-computed first vector, then ready tied high
    m_lfsr = 32'h1;
    push_run();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("latency_low", 32'(vif.out_valid), 32'h0);
    end
    @(posedge clk); #1;
    check_first_vector("first");
    repeat (3) @(posedge clk);
    #1 vif.out_ready = 1'b1;
    wait_done(2500, ok);
    check("sweep1_finished", 32'(ok), 32'h1);
    check("sweep1_done",  32'(done),          32'h1);
    check("sweep1_busy",  32'(busy),          32'h0);
    check("sweep1_op",    32'(vif.op),        32'h0);
    check("sweep1_idx",   32'(vif.test_idx),  32'h0);
    check("sweep1_valid", 32'(vif.out_valid), 32'h0);
    check("sweep1_hs",    32'(hs),            32'd400);
    check("sweep1_left",  32'(exp_q.size()),  32'h0);
    check("all_hs",   32'(hs_all),    32'd16);
    check("all_done", 32'(done_all),  32'h1);
    check("none_hs",  32'(hs_none),   32'd100);
    check("none_done",32'(done_none), 32'h1);

    // Sweep 2: restart from DONE, start held high, random backpressure
    push_run();
    start = 1'b1;
    @(posedge clk); #1;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      vif.out_ready = ($urandom_range(0, 9) < 3);
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    vif.out_ready = 1'b1;
    check("sweep2_finished", 32'(ok), 32'h1);
    check("sweep2_hs",   32'(hs),           32'd800);
    check("sweep2_left", 32'(exp_q.size()), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("sweep2_done_hold",  32'(done),          32'h1);
    check("sweep2_valid_hold", 32'(vif.out_valid), 32'h0);

    // Sweep 3: reset at vector 150, then a fresh run must repeat from the start
    push_run();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (hs >= 950) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_vec150", 32'(ok), 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    m_lfsr = 32'h1;
    #1;
    check("midrst_valid", 32'(vif.out_valid), 32'h0);
    check("midrst_op",    32'(vif.op),        32'h0);
    check("midrst_idx",   32'(vif.test_idx),  32'h0);
    check("midrst_a",     vif.a,              32'h0);
    check("midrst_busy",  32'(busy),          32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_run();
    vif.out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_first_vector("post_reset");
    vif.out_ready = 1'b1;
    wait_done(2500, ok);
    check("sweep3_finished", 32'(ok), 32'h1);
    check("sweep3_hs",   32'(hs),           32'd1350);
    check("sweep3_left", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
